// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_t : two-state fetch/issue FSM encoding
//   - field positions of the opcode, function, jump index and branch
//     immediate inside a 32-bit instruction word
//   - DEFAULT_RESET_PC : PC loaded on reset unless overridden
package instr_fetch_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_ISSUE = 1'b1
  } fetch_state_t;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int JIDX_MSB  = 25;
  localparam int IMM_MSB   = 15;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_next_pc_gen.sv
// next_pc_gen
// Purely combinational next-PC selection for the fetch unit.
// Ports:
//   pc      in  32  address of the current instruction
//   instr   in  32  current instruction word
//   Branch  in   1  decoded branch indication
//   Jump    in   1  decoded jump indication
//   zero    in   1  ALU zero flag
//   next_pc out 32  address of the following instruction
module next_pc_gen
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic        unused_op_bits;

  // The opcode bits are decoded elsewhere; they play no part in the target.
  assign unused_op_bits = ^instr[OP_MSB:OP_LSB];

  assign pc4           = pc + 32'd4;
  // Jump keeps the upper nibble of the sequential address (region-relative).
  assign jump_target   = {pc4[31:28], instr[JIDX_MSB:0], 2'b00};
  // Word offset, sign-extended, scaled to bytes; wraps modulo 2^32.
  assign branch_offset = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
  assign branch_target = pc4 + branch_offset;

  // Jump has priority over a taken branch.
  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Fetch/issue unit: requests one instruction at a time from instruction
// memory, holds it for decode/execute, and advances the PC when the
// datapath retires it.
// Ports:
//   clk          in   1  rising-edge clock
//   rst          in   1  asynchronous active-high reset
//   imem_req     out  1  fetch request
//   imem_addr    out 32  fetch byte address (always the current pc)
//   imem_ready   in   1  imem_rdata valid this cycle
//   imem_rdata   in  32  instruction word from memory
//   instr        out 32  held instruction
//   op           out  6  instr[31:26]
//   func         out  6  instr[5:0]
//   instr_valid  out  1  instr/op/func valid for decode
//   retire       in   1  datapath finished the current instruction
//   Branch       in   1  branch indication (sampled on retire)
//   Jump         in   1  jump indication (sampled on retire)
//   zero         in   1  ALU zero flag (sampled on retire)
//   pc           out 32  address of the current instruction
//   retired_cnt  out 32  number of retired instructions (wraps)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] retired_cnt
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         load_instr;
  logic         advance_pc;
  logic [31:0]  next_pc;

  next_pc_gen u_next_pc_gen (
    .pc      (pc),
    .instr   (instr),
    .Branch  (Branch),
    .Jump    (Jump),
    .zero    (zero),
    .next_pc (next_pc)
  );

  assign imem_addr = pc;
  assign op        = instr[OP_MSB:OP_LSB];
  assign func      = instr[FUNC_MSB:FUNC_LSB];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs. retire while fetching and imem_ready while
  // issuing fall through to the defaults, so they are ignored.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;
    advance_pc  = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (retire) begin
          advance_pc = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      retired_cnt <= 32'h0;
    end else begin
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (advance_pc) begin
        pc          <= next_pc;
        retired_cnt <= retired_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_instr_fetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        instr_valid;
  logic        retire;
  logic        Branch;
  logic        Jump;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] retired_cnt;

  int checks;
  int failures;

  // Reference model: pc, held instruction, retire count and whether an
  // instruction is currently held for issue.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  logic        m_holding;

  instr_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .func        (func),
    .instr_valid (instr_valid),
    .retire      (retire),
    .Branch      (Branch),
    .Jump        (Jump),
    .zero        (zero),
    .pc          (pc),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural next-PC rule written with plain integer arithmetic.
  function automatic logic [31:0] refNextPc(input logic [31:0] cur_pc,
                                            input logic [31:0] ins,
                                            input logic br, input logic jmp,
                                            input logic zf);
    logic [31:0] seq;
    int          imm;
    seq = cur_pc + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
    if (br && zf) begin
      imm = int'($signed(ins[15:0]));
      return seq + 32'(imm * 4);
    end
    return seq;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".pc"}, pc, m_pc);
    checkOutput({tag, ".addr"}, imem_addr, m_pc);
    checkOutput({tag, ".req"}, {31'd0, imem_req}, {31'd0, !m_holding});
    checkOutput({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, m_holding});
    checkOutput({tag, ".instr"}, instr, m_instr);
    checkOutput({tag, ".op"}, {26'd0, op}, {26'd0, m_instr[31:26]});
    checkOutput({tag, ".func"}, {26'd0, func}, {26'd0, m_instr[5:0]});
    checkOutput({tag, ".cnt"}, retired_cnt, m_cnt);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // compare everything #1 after the edge.
  task automatic applyStimulus(input string tag, input logic rdy,
                               input logic [31:0] rdata, input logic ret,
                               input logic br, input logic jmp,
                               input logic zf);
    imem_ready = rdy;
    imem_rdata = rdata;
    retire     = ret;
    Branch     = br;
    Jump       = jmp;
    zero       = zf;
    if (!m_holding && rdy) begin
      m_instr   = rdata;
      m_holding = 1'b1;
    end else if (m_holding && ret) begin
      m_pc      = refNextPc(m_pc, m_instr, br, jmp, zf);
      m_cnt     = m_cnt + 32'd1;
      m_holding = 1'b0;
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic modelReset();
    m_pc      = TB_RESET_PC;
    m_instr   = 32'h0;
    m_cnt     = 32'h0;
    m_holding = 1'b0;
  endtask

  // Fetch with zero wait then retire with the given decode flags.
  task automatic runInstr(input string tag, input logic [31:0] ins,
                          input logic br, input logic jmp, input logic zf);
    applyStimulus({tag, ".f"}, 1'b1, ins, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus({tag, ".r"}, 1'b0, 32'h0, 1'b1, br, jmp, zf);
  endtask

  initial begin
    logic [31:0] held_addr;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    retire     = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    zero       = 1'b0;
    modelReset();

    #12;
    checkAll("reset");
    #1 rst = 1'b0;

    // Zero-wait fetch of 0x2002_0005 from address 0, then retire.
    checkOutput("first.addr_c0", imem_addr, 32'h0);
    applyStimulus("first.fetch", 1'b1, 32'h2002_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("first.op", {26'd0, op}, 32'h08);
    applyStimulus("first.retire", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("first.pc4", pc, 32'h4);
    checkOutput("first.cnt1", retired_cnt, 32'h1);

    // Jump to 0x100, then a beq with imm=-1, taken then not taken.
    runInstr("to100", 32'h0800_0040, 1'b0, 1'b1, 1'b0);
    checkOutput("to100.pc", pc, 32'h100);
    runInstr("beq_taken", 32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
    checkOutput("beq_taken.pc", pc, 32'h100);
    runInstr("beq_not", 32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
    checkOutput("beq_not.pc", pc, 32'h104);

    // Jump beats branch.
    runInstr("to400000", 32'h0810_0000, 1'b0, 1'b1, 1'b0);
    checkOutput("to400000.pc", pc, 32'h0040_0000);
    runInstr("jprio", 32'h0810_0004, 1'b1, 1'b1, 1'b1);
    checkOutput("jprio.pc", pc, 32'h0040_0010);

    // Memory stall with stray retire pulses.
    held_addr = imem_addr;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("stall", 1'b0, $urandom, i[0], 1'b1, 1'b1, 1'b1);
      checkOutput("stall.addr_hold", imem_addr, held_addr);
    end
    applyStimulus("stall.end", 1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("issue.ready_ign", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("stall.ret", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reach 0xFFFF_FFFC, then wrap pc and retired_cnt together.
    runInstr("to0", 32'h0800_0000, 1'b0, 1'b1, 1'b0);
    runInstr("toTop", 32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
    checkOutput("toTop.pc", pc, 32'hFFFF_FFFC);
    applyStimulus("wrap.fetch", 1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    m_cnt = 32'hFFFF_FFFF;
    applyStimulus("wrap.retire", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap.pc", pc, 32'h0);
    checkOutput("wrap.cnt", retired_cnt, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 2) != 0), $urandom,
                    ($urandom_range(0, 2) != 0), 1'($urandom),
                    ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Asynchronous reset in the middle of an issue.
    applyStimulus("pre_rst.fetch", 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    checkOutput("restart.addr", imem_addr, TB_RESET_PC);
    applyStimulus("restart.fetch", 1'b1, 32'h2002_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("restart.retire", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
